// File: rtl/iterative_alu.sv
// Multi-cycle execute ALU: single-cycle logic/arith/compare, 1-bit-per-cycle shifter.
// Define ITERATIVE_ALU_BARREL_SHIFT_EN to replace the iterative shifter with a one-cycle barrel shifter.
module iterative_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
);
    localparam int SHAMT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nxt;

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               lt_s, lt_u;

    assign shamt = SrcB[SHAMT_W-1:0];
    assign lt_s  = $signed(SrcA) < $signed(SrcB);
    assign lt_u  = SrcA < SrcB;
    assign busy  = (state != IDLE);
    assign done  = (state == DONE);

    always_comb begin
        alu_res = '0;
        case (ALUControl)
            4'b0000, 4'b1001: alu_res = SrcA + SrcB;
            4'b0001:          alu_res = SrcA - SrcB;
            4'b0010:          alu_res = SrcA & SrcB;
            4'b0011:          alu_res = SrcA | SrcB;
            4'b0110:          alu_res = SrcA ^ SrcB;
            4'b0101, 4'b1101: alu_res = {{(WIDTH-1){1'b0}}, lt_s};
            4'b1111:          alu_res = {{(WIDTH-1){1'b0}}, lt_u};
`ifdef ITERATIVE_ALU_BARREL_SHIFT_EN
            4'b0100:          alu_res = SrcA << shamt;
            4'b0111:          alu_res = SrcA >> shamt;
            4'b1000:          alu_res = WIDTH'($signed(SrcA) >>> shamt);
`endif
            default:          alu_res = '0;
        endcase
    end

`ifdef ITERATIVE_ALU_BARREL_SHIFT_EN
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ALUResult <= '0;
            Zero      <= 1'b1;
        end else if (state == IDLE && start) begin
            ALUResult <= alu_res;
            Zero      <= (alu_res == '0);
        end
    end
`else
    logic               is_shift;
    logic [WIDTH-1:0]   shreg, sh1;
    logic [SHAMT_W-1:0] cnt;
    logic [3:0]         op;

    assign is_shift = (ALUControl == 4'b0100) || (ALUControl == 4'b0111) || (ALUControl == 4'b1000);

    always_comb begin
        case (op)
            4'b0100: sh1 = {shreg[WIDTH-2:0], 1'b0};
            4'b0111: sh1 = {1'b0, shreg[WIDTH-1:1]};
            default: sh1 = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (is_shift && shamt != '0) ? SHIFT : DONE;
            SHIFT:   if (cnt == SHAMT_W'(1)) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ALUResult <= '0;
            Zero      <= 1'b1;
            shreg     <= '0;
            cnt       <= '0;
            op        <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    if (is_shift && shamt != '0) begin
                        shreg <= SrcA;
                        cnt   <= shamt;
                        op    <= ALUControl;
                    end else begin
                        // shift by zero passes SrcA through; alu_res is 0 for shift codes
                        ALUResult <= is_shift ? SrcA : alu_res;
                        Zero      <= is_shift ? (SrcA == '0) : (alu_res == '0);
                    end
                end
                SHIFT: begin
                    shreg <= sh1;
                    cnt   <= cnt - SHAMT_W'(1);
                    if (cnt == SHAMT_W'(1)) begin
                        ALUResult <= sh1;
                        Zero      <= (sh1 == '0);
                    end
                end
                default: ;
            endcase
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end
endmodule

// File: tb/tb_iterative_alu.sv
// Directed self-checking bench for iterative_alu (WIDTH=32), latency-aware for both shifter builds.
module tb_iterative_alu;
    logic        clk = 0, reset = 1, start = 0;
    logic [3:0]  ALUControl = '0;
    logic [31:0] SrcA = '0, SrcB = '0;
    logic        busy, done, Zero;
    logic [31:0] ALUResult;
    int total = 0, bad = 0;

`ifdef ITERATIVE_ALU_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    iterative_alu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .ALUControl(ALUControl),
        .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done),
        .ALUResult(ALUResult), .Zero(Zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int shlat(input int n);
        return (BARREL || n == 0) ? 1 : n + 1;
    endfunction

    // launch one op, scramble inputs after the start edge, measure latency to done
    task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int explat);
        int n;
        @(negedge clk);
        ALUControl = c; SrcA = a; SrcB = b; start = 1;
        @(posedge clk); #1;
        start = 0; SrcA = ~a; SrcB = 32'h1234_5678; ALUControl = 4'b0001;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        chk({tag, ".lat"}, n, explat);
        chk({tag, ".res"}, ALUResult, exp);
        chk({tag, ".zero"}, {31'b0, Zero}, {31'b0, exp == 32'h0});
    endtask

    initial begin
        int n, pulses;
        #12;
        chk("rst.busy", {31'b0, busy}, 0);
        chk("rst.done", {31'b0, done}, 0);
        chk("rst.res", ALUResult, 0);
        chk("rst.zero", {31'b0, Zero}, 1);
        @(negedge clk); reset = 0;

        run_op("sub",   4'b0001, 32'd5, 32'd5, 32'd0, 1);
        run_op("addw",  4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        run_op("addls", 4'b1001, 32'd3, 32'd4, 32'd7, 1);
        run_op("and",   4'b0010, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1);
        run_op("or",    4'b0011, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1);
        run_op("xor",   4'b0110, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1);
        run_op("slt",   4'b0101, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        run_op("sltb",  4'b1101, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        run_op("sltu",  4'b1111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        run_op("sra4",  4'b1000, 32'h8000_0000, 32'd4, 32'hF800_0000, shlat(4));
        run_op("sll5",  4'b0100, 32'h0000_0003, 32'h25, 32'h0000_0060, shlat(5));
        run_op("srl31", 4'b0111, 32'hF000_0000, 32'd31, 32'd1, shlat(31));
        run_op("sll0",  4'b0100, 32'hA5A5_0000, 32'h20, 32'hA5A5_0000, 1);
        run_op("undef", 4'b1010, 32'd9, 32'd9, 32'd0, 1);

        // start pulses while busy are ignored
        @(negedge clk);
        ALUControl = 4'b0100; SrcA = 32'd1; SrcB = 32'd20; start = 1;
        @(posedge clk); #1; start = 0;
        n = 0;
        while (n < 100) begin
            @(negedge clk); n++;
            if (done) break;
            start = n[0]; ALUControl = 4'b0000; SrcA = 32'h55; SrcB = 32'h7;
        end
        chk("hs.lat", n, shlat(20));
        chk("hs.res", ALUResult, 32'h0010_0000);
        // start on the done cycle is dropped, held into the next cycle it is taken
        start = 1; ALUControl = 4'b0000; SrcA = 32'd1; SrcB = 32'd1;
        @(negedge clk);
        chk("hs.ign.busy", {31'b0, busy}, 0);
        chk("hs.ign.res", ALUResult, 32'h0010_0000);
        @(negedge clk); start = 0;
        chk("hs.acc.done", {31'b0, done}, 1);
        chk("hs.acc.res", ALUResult, 32'd2);

        // reset mid-shift discards the operation
        @(negedge clk);
        ALUControl = 4'b0100; SrcA = 32'd1; SrcB = 32'd20; start = 1;
        @(negedge clk); start = 0;
        repeat (4) @(negedge clk);
        if (!BARREL) chk("mid.busy", {31'b0, busy}, 1);
        reset = 1; #1;
        chk("mr.busy", {31'b0, busy}, 0);
        chk("mr.done", {31'b0, done}, 0);
        chk("mr.res", ALUResult, 0);
        chk("mr.zero", {31'b0, Zero}, 1);
        @(negedge clk); reset = 0;
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("mr.nodone", pulses, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
